gpo_pad_tx: RTL and testbench
=============================

Name: gpo_pad_tx

Overview:
Core-side transmit controller for a bidirectional GPIO pad.
- Serialises bytes onto the pad output path as UART-style frames.
- Drives the pad's data-out (DO_O) and output-enable (OE_O) pins, sequencing OE around each burst.
- Releases the pad between bursts, so the receiving end's pull-up holds the line high while it is undriven.
- Accepts bytes over a valid/ready handshake through a one-entry holding buffer.

Parameters:
CLKDIV, 16, clock cycles per bit-time; legal range >= 2.
LEAD_BITS, 1, bit-times of driven idle-high after OE rises and before the first start bit; legal range >= 1.
HOLD_BITS, 2, bit-times of driven idle-high after the last stop bit before OE falls; legal range >= 1.

Ports:
CLK_I  in  1  core clock; all logic on the rising edge.
RST_I  in  1  synchronous, active-high reset.
DATA_I  in  8  byte to transmit.
VALID_I  in  1  DATA_I is valid.
READY_O  out  1  holding buffer empty; a transfer occurs on the edge where VALID_I and READY_O are both 1.
DO_O  out  1  pad data-out.
OE_O  out  1  pad output enable.
BUSY_O  out  1  state is not IDLE, or the buffer is full.
DI_I  in  1  pad receiver readback; used only with the optional feature.
ERR_O  out  1  sticky contention flag; present only with the optional feature.

Behaviour:
- Reset (RST_I=1 at a clock edge):
  - state=IDLE, buffer empty, counters cleared.
  - DO_O=1, OE_O=0, BUSY_O=0, ERR_O=0.
  - READY_O is forced to 0 while RST_I=1 and rises in the first cycle after release.
  - Reset mid-frame: OE_O=0 and DO_O=1 from the next edge; the buffered byte and the in-flight byte are discarded.
- All outputs are registered except READY_O, which equals !buf_full (forced 0 during reset).
- Bit timer: counts 0..CLKDIV-1. A bit-time ends when the count reaches CLKDIV-1. Every state change except IDLE->LEAD happens at a bit-time end.
- FSM states and transitions:
  - IDLE: OE_O=0, DO_O=1. If buffer full, go to LEAD on the next edge and restart the timer.
  - LEAD: OE_O=1, DO_O=1 for LEAD_BITS bit-times, then go to START.
  - START: load the buffer into the shift register and free the buffer (READY_O=1 from the next cycle). DO_O=0 for one bit-time, then go to DATA.
  - DATA: 8 bit-times, LSB first, DO_O=shift[0]. Shift right at the end of each bit-time. Then go to STOP.
  - STOP: DO_O=1 for one bit-time. At its end: buffer full goes to START (no gap); buffer empty goes to HOLD.
  - HOLD: OE_O=1, DO_O=1.
    - Buffer becomes full: go to START at the next bit-time end.
    - After HOLD_BITS bit-times with the buffer empty: go to IDLE; OE_O=0 on that edge.
- Latency: the first start bit begins 1 + LEAD_BITS*CLKDIV cycles after the accepting edge, measured from IDLE.
- Burst length: OE_O stays high continuously for back-to-back bytes. OE-high time = (LEAD_BITS + 10*N + HOLD_BITS)*CLKDIV cycles for N bytes.
- OE/DO ordering: DO_O is 1 on any edge where OE_O changes, so the pad never glitches low.
- Handshake and buffering:
  - VALID_I with READY_O=0 stalls; DATA_I must stay stable until accepted.
  - An accept and a START load on the same edge are legal: the old byte moves to the shift register and the new byte fills the buffer.

Optional Feature:
Macro: GPO_LOOPBACK_CHECK_EN.
- Defined:
  - At timer count CLKDIV/2 in states LEAD, START, DATA, STOP and HOLD, compare DI_I with DO_O.
  - On mismatch, set ERR_O=1 on that edge. ERR_O is cleared only by reset.
  - The transmit sequence is not affected.
- Not defined: DI_I is unused, ERR_O is tied to 0, and no comparison logic is built.

Test Plan:
1. CLKDIV=4, LEAD=1, HOLD=2; send 0xA5 from IDLE. Required response:
   - OE_O rises 1 cycle after accept; DO_O=1 for 4 cycles.
   - Start bit 0 for 4 cycles.
   - Data bits 1,0,1,0,0,1,0,1, each 4 cycles.
   - Stop bit 1 for 4 cycles, then 8 cycles of driven high.
   - OE_O falls; OE-high time = 52 cycles.
2. Back-to-back: send 0x00, then 0xFF while the first byte is in DATA. Required response: the stop bit of 0x00 is followed immediately by the start bit of 0xFF; OE_O stays high throughout; READY_O drops after the second accept and rises at START of 0xFF.
3. Hold re-arm: send 0x3C, then present the next byte 3 cycles into HOLD. Required response: START follows at the next bit-time end, OE_O never drops, and no LEAD phase occurs.
4. Reset mid-frame: assert RST_I during DATA bit 4 for 1 cycle. Required response: next edge gives OE_O=0, DO_O=1, BUSY_O=0; READY_O=0 during reset and 1 after; the next byte starts with a full LEAD phase.
5. Backpressure: hold VALID_I=1 with 3 bytes queued. Required response: READY_O=0 whenever the buffer is full; all 3 bytes appear in order with no loss or duplication.
6. GPO_LOOPBACK_CHECK_EN defined: force DI_I=0 during the STOP bit. Required response: ERR_O=1 from the mid-bit sample onward and through the rest of the frame; ERR_O=0 after reset.

Source files
------------

// File: rtl/gpo_pad_tx.sv
// GPIO pad transmit controller: UART-style frames on DO_O with OE_O sequenced around each burst.
// Optional loopback contention check on DI_I is built when GPO_LOOPBACK_CHECK_EN is defined.
module gpo_pad_tx #(
  parameter int CLKDIV    = 16,
  parameter int LEAD_BITS = 1,
  parameter int HOLD_BITS = 2
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic [7:0] DATA_I,
  input  logic       VALID_I,
  output logic       READY_O,
  output logic       DO_O,
  output logic       OE_O,
  output logic       BUSY_O,
  input  logic       DI_I,
  output logic       ERR_O
);

  localparam int TW   = $clog2(CLKDIV);
  localparam int MAXB = (LEAD_BITS > HOLD_BITS)
                        ? ((LEAD_BITS > 8) ? LEAD_BITS : 8)
                        : ((HOLD_BITS > 8) ? HOLD_BITS : 8);
  localparam int CW   = $clog2(MAXB);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_START,
    S_DATA,
    S_STOP,
    S_HOLD
  } state_t;

  state_t          state;
  logic [TW-1:0]   tmr;
  logic [CW-1:0]   cnt;
  logic [7:0]      shift;
  logic [7:0]      buf_dat;
  logic            buf_full;
  logic            do_q;
  logic            oe_q;
  logic            busy_q;

  logic bit_end;
  logic accept;
  logic lead_done;
  logic hold_done;
  logic load;
  logic idle_nxt;

  assign bit_end   = (tmr == TW'(CLKDIV - 1));
  assign READY_O   = !buf_full && !RST_I;
  assign accept    = VALID_I && READY_O;
  assign lead_done = (cnt == CW'(LEAD_BITS - 1));
  assign hold_done = (cnt == CW'(HOLD_BITS - 1));

  // The buffer empties on every edge that enters START.
  assign load = bit_end && (((state == S_LEAD) && lead_done) ||
                            (((state == S_STOP) || (state == S_HOLD)) && buf_full));

  // In both idle-bound cases the buffer is empty, so only a same-edge accept keeps BUSY_O up.
  assign idle_nxt = !buf_full && ((state == S_IDLE) ||
                                  ((state == S_HOLD) && bit_end && hold_done));

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      buf_full <= 1'b0;
      buf_dat  <= 8'h00;
    end else if (accept) begin
      buf_full <= 1'b1;
      buf_dat  <= DATA_I;
    end else if (load) begin
      buf_full <= 1'b0;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state  <= S_IDLE;
      tmr    <= '0;
      cnt    <= '0;
      shift  <= 8'h00;
      do_q   <= 1'b1;
      oe_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      busy_q <= !idle_nxt || accept;

      if (state == S_IDLE || bit_end) tmr <= '0;
      else                            tmr <= tmr + TW'(1);

      case (state)
        S_IDLE: begin
          if (buf_full) begin
            state <= S_LEAD;
            cnt   <= '0;
            oe_q  <= 1'b1;
            do_q  <= 1'b1;
          end
        end
        S_LEAD: begin
          if (bit_end) begin
            if (lead_done) begin
              state <= S_START;
              shift <= buf_dat;
              cnt   <= '0;
              do_q  <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_START: begin
          if (bit_end) begin
            state <= S_DATA;
            cnt   <= '0;
            do_q  <= shift[0];
          end
        end
        S_DATA: begin
          if (bit_end) begin
            shift <= {1'b0, shift[7:1]};
            if (cnt == CW'(7)) begin
              state <= S_STOP;
              cnt   <= '0;
              do_q  <= 1'b1;
            end else begin
              cnt  <= cnt + CW'(1);
              do_q <= shift[1];
            end
          end
        end
        S_STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (buf_full) begin
              state <= S_START;
              shift <= buf_dat;
              do_q  <= 1'b0;
            end else begin
              state <= S_HOLD;
              do_q  <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (bit_end) begin
            if (buf_full) begin
              state <= S_START;
              shift <= buf_dat;
              cnt   <= '0;
              do_q  <= 1'b0;
            end else if (hold_done) begin
              state <= S_IDLE;
              cnt   <= '0;
              oe_q  <= 1'b0;
              do_q  <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: begin
          state <= S_IDLE;
          oe_q  <= 1'b0;
          do_q  <= 1'b1;
        end
      endcase
    end
  end

  assign DO_O   = do_q;
  assign OE_O   = oe_q;
  assign BUSY_O = busy_q;

`ifdef GPO_LOOPBACK_CHECK_EN
  logic err_q;

  // Readback is compared mid-bit, where the pad has had half a bit-time to settle.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      err_q <= 1'b0;
    end else if ((state != S_IDLE) && (tmr == TW'(CLKDIV / 2)) && (DI_I != do_q)) begin
      err_q <= 1'b1;
    end
  end

  assign ERR_O = err_q;
`else
  logic unused_di;
  assign unused_di = DI_I;
  assign ERR_O     = 1'b0;
`endif

endmodule

// File: tb/tb_gpo_pad_tx.sv
// Testbench for gpo_pad_tx: directed scenarios with a frame-decoding scoreboard on the pad pins.
module tb_gpo_pad_tx;

  localparam int CLKDIV    = 4;
  localparam int LEAD_BITS = 1;
  localparam int HOLD_BITS = 2;

`ifdef GPO_LOOPBACK_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       do_pin;
  logic       oe_pin;
  logic       busy;
  logic       err;
  logic       di_force;
  logic       di_val;
  wire        di_pad = di_force ? di_val : (oe_pin ? do_pin : 1'b1);

  int checks = 0;
  int errors = 0;
  int frames_seen = 0;
  logic [7:0] exp_q[$];

  gpo_pad_tx #(
    .CLKDIV   (CLKDIV),
    .LEAD_BITS(LEAD_BITS),
    .HOLD_BITS(HOLD_BITS)
  ) dut (
    .CLK_I  (clk),
    .RST_I  (rst),
    .DATA_I (data),
    .VALID_I(valid),
    .READY_O(ready),
    .DO_O   (do_pin),
    .OE_O   (oe_pin),
    .BUSY_O (busy),
    .DI_I   (di_pad),
    .ERR_O  (err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Frame decoder: samples mid-bit, pops the scoreboard at each stop bit.
  int         mon_cnt = -1;
  logic [7:0] mon_byte = 8'h00;
  logic       prev_oe = 1'b0;

  always @(posedge clk) begin
    #1;
    if (oe_pin !== prev_oe) begin
      checks++;
      if (do_pin !== 1'b1) begin
        errors++;
        $display("FAIL oe_edge_do: DO_O=%b on OE change, required 1", do_pin);
      end
    end
    prev_oe = oe_pin;
    if (mon_cnt < 0) begin
      if (oe_pin === 1'b1 && do_pin === 1'b0) mon_cnt = 0;
    end else if (oe_pin !== 1'b1) begin
      mon_cnt = -1;
    end else begin
      mon_cnt++;
      if (mon_cnt >= 6 && mon_cnt <= 34 && ((mon_cnt - 6) % 4) == 0)
        mon_byte[(mon_cnt - 6) / 4] = do_pin;
      if (mon_cnt == 38) begin
        frames_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame_unexpected: got 0x%02h, nothing expected", mon_byte);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (mon_byte !== e || do_pin !== 1'b1) begin
            errors++;
            $display("FAIL frame_data: got 0x%02h stop=%b, required 0x%02h stop=1",
                     mon_byte, do_pin, e);
          end
        end
        mon_cnt = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit keep, output int stalls);
    stalls = 0;
    data   = b;
    valid  = 1'b1;
    while (ready !== 1'b1 && stalls < 300) begin
      tick();
      stalls++;
    end
    if (ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: READY_O=%b for byte 0x%02h, required 1", ready, b);
      valid = 1'b0;
    end else begin
      tick();
      exp_q.push_back(b);
      if (!keep) valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy !== 1'b0 || mon_cnt >= 0) && n < 500) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: BUSY_O=%b, required 0", busy);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (ready !== 1'b0 || oe_pin !== 1'b0 || do_pin !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: RDY/OE/DO/BUSY/ERR=%b%b%b%b%b, required 00100",
               ready, oe_pin, do_pin, busy, err);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: READY_O=%b, required 1", ready);
    end
    tick();
  endtask

  task automatic test_single();
    logic [7:0] b;
    logic       e [0:51];
    int         st;
    b = 8'hA5;
    for (int i = 0; i < 52; i++) begin
      if (i < 4)       e[i] = 1'b1;
      else if (i < 8)  e[i] = 1'b0;
      else if (i < 40) e[i] = b[(i - 8) / 4];
      else             e[i] = 1'b1;
    end
    send_byte(b, 1'b0, st);
    checks++;
    if (oe_pin !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_accept: OE_O=%b BUSY_O=%b, required 0 1", oe_pin, busy);
    end
    for (int c = 1; c <= 52; c++) begin
      tick();
      checks++;
      if (oe_pin !== 1'b1 || do_pin !== e[c-1]) begin
        errors++;
        $display("FAIL single_wave c=%0d: OE/DO=%b%b, required 1%b", c, oe_pin, do_pin, e[c-1]);
      end
      if (c == 4 || c == 5) begin
        checks++;
        if (ready !== (c == 5)) begin
          errors++;
          $display("FAIL single_ready c=%0d: READY_O=%b, required %0d", c, ready, (c == 5));
        end
      end
    end
    tick();
    checks++;
    if (oe_pin !== 1'b0 || do_pin !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_end: OE/DO/BUSY=%b%b%b, required 010", oe_pin, do_pin, busy);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int st;
    send_byte(8'h00, 1'b0, st);
    for (int c = 1; c <= 92; c++) begin
      tick();
      if (c == 12) begin
        checks++;
        if (ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready_data: READY_O=%b, required 1", ready);
        end
        data  = 8'hFF;
        valid = 1'b1;
      end
      if (c == 13) begin
        valid = 1'b0;
        exp_q.push_back(8'hFF);
        checks++;
        if (ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_ready_full: READY_O=%b, required 0", ready);
        end
      end
      checks++;
      if (oe_pin !== 1'b1) begin
        errors++;
        $display("FAIL b2b_oe c=%0d: OE_O=%b, required 1", c, oe_pin);
      end
      if (c == 44 || c == 45) begin
        checks++;
        if (do_pin !== (c == 44) || ready !== (c == 45)) begin
          errors++;
          $display("FAIL b2b_seam c=%0d: DO_O=%b READY_O=%b, required %0d %0d",
                   c, do_pin, ready, (c == 44), (c == 45));
        end
      end
    end
    tick();
    checks++;
    if (oe_pin !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: OE_O=%b, required 0", oe_pin);
    end
    wait_idle();
  endtask

  task automatic test_hold_rearm();
    int st;
    send_byte(8'h3C, 1'b0, st);
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (c == 48) begin
        data  = 8'h77;
        valid = 1'b1;
      end
      if (c == 49) begin
        valid = 1'b0;
        exp_q.push_back(8'h77);
      end
      checks++;
      if (oe_pin !== 1'b1) begin
        errors++;
        $display("FAIL hold_oe c=%0d: OE_O=%b, required 1", c, oe_pin);
      end
      if (c == 52 || c == 53) begin
        checks++;
        if (do_pin !== (c == 52)) begin
          errors++;
          $display("FAIL hold_restart c=%0d: DO_O=%b, required %0d", c, do_pin, (c == 52));
        end
      end
    end
    tick();
    checks++;
    if (oe_pin !== 1'b0) begin
      errors++;
      $display("FAIL hold_end: OE_O=%b, required 0", oe_pin);
    end
    wait_idle();
  endtask

  task automatic test_reset_midframe();
    int st;
    send_byte(8'h5A, 1'b0, st);
    for (int c = 1; c <= 26; c++) begin
      tick();
      if (c == 12) begin
        data  = 8'hC3;
        valid = 1'b1;
      end
      if (c == 13) valid = 1'b0;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ready_low: READY_O=%b, required 0", ready);
    end
    tick();
    checks++;
    if (oe_pin !== 1'b0 || do_pin !== 1'b1 || busy !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: OE/DO/BUSY/RDY=%b%b%b%b, required 0100",
               oe_pin, do_pin, busy, ready);
    end
    rst = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ready_high: READY_O=%b, required 1", ready);
    end
    tick();
    send_byte(8'h81, 1'b0, st);
    for (int c = 1; c <= 5; c++) begin
      tick();
      checks++;
      if (oe_pin !== 1'b1 || do_pin !== (c < 5)) begin
        errors++;
        $display("FAIL midrst_lead c=%0d: OE/DO=%b%b, required 1%0d", c, oe_pin, do_pin, (c < 5));
      end
    end
    wait_idle();
  endtask

  task automatic test_backpressure();
    logic [7:0] bytes [3];
    int         st [3];
    int         exp_st [3];
    bytes  = '{8'h11, 8'h22, 8'h33};
    exp_st = '{0, 5, 39};
    for (int i = 0; i < 3; i++) begin
      send_byte(bytes[i], (i < 2), st[i]);
      checks++;
      if (ready !== 1'b0 || st[i] != exp_st[i]) begin
        errors++;
        $display("FAIL bp_byte%0d: READY_O=%b stalls=%0d, required 0 %0d",
                 i, ready, st[i], exp_st[i]);
      end
    end
    wait_idle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: %0d bytes outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_loopback();
    int st;
    send_byte(8'hA5, 1'b0, st);
    for (int c = 1; c <= 52; c++) begin
      tick();
      if (c == 41) begin
        di_force = 1'b1;
        di_val   = 1'b0;
      end
      if (c == 45) di_force = 1'b0;
      if (c == 43) begin
        checks++;
        if (err !== 1'b0) begin
          errors++;
          $display("FAIL lb_before: ERR_O=%b, required 0", err);
        end
      end
      if (c >= 44) begin
        checks++;
        if (err !== ERR_EXP) begin
          errors++;
          $display("FAIL lb_sticky c=%0d: ERR_O=%b, required %b", c, err, ERR_EXP);
        end
      end
    end
    wait_idle();
    checks++;
    if (err !== ERR_EXP) begin
      errors++;
      $display("FAIL lb_idle: ERR_O=%b, required %b", err, ERR_EXP);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL lb_reset: ERR_O=%b, required 0", err);
    end
    tick();
  endtask

  initial begin
    rst      = 1'b1;
    data     = 8'h00;
    valid    = 1'b0;
    di_force = 1'b0;
    di_val   = 1'b1;

    test_reset();
    test_single();
    test_back_to_back();
    test_hold_rearm();
    test_reset_midframe();
    test_backpressure();
    test_loopback();

    checks++;
    if (frames_seen != 10 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL frame_count: frames=%0d outstanding=%0d, required 10 0",
               frames_seen, exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
